// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module   : logic_unit_pipe
// Brief    : Eight-op bitwise logic unit feeding a 2-entry valid/ready skid
//            buffer. Optional zero flag via LOGIC_UNIT_ZFLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_opA,
  input  logic [WIDTH-1:0] i_opB,
  input  logic [2:0]       i_instr_type,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result
`ifdef LOGIC_UNIT_ZFLAG_EN
  ,
  output logic             o_zero
`endif
);

  localparam logic [2:0] c_OP_XOR  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_AND  = 3'b010;
  localparam logic [2:0] c_OP_XNOR = 3'b011;
  localparam logic [2:0] c_OP_NOR  = 3'b100;
  localparam logic [2:0] c_OP_NAND = 3'b101;
  localparam logic [2:0] c_OP_ANDN = 3'b110;

  localparam logic [1:0] c_CNT_EMPTY = 2'd0;
  localparam logic [1:0] c_CNT_ONE   = 2'd1;
  localparam logic [1:0] c_CNT_FULL  = 2'd2;

  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_result;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_result = '0;
    case (i_instr_type)
      c_OP_XOR:  w_result = i_opA ^ i_opB;
      c_OP_OR:   w_result = i_opA | i_opB;
      c_OP_AND:  w_result = i_opA & i_opB;
      c_OP_XNOR: w_result = ~(i_opA ^ i_opB);
      c_OP_NOR:  w_result = ~(i_opA | i_opB);
      c_OP_NAND: w_result = ~(i_opA & i_opB);
      c_OP_ANDN: w_result = i_opA & ~i_opB;
      default:   w_result = i_opA | ~i_opB;
    endcase
  end

  // Handshake decoded from registered occupancy only, so i_ready never
  // reaches o_ready combinationally.
  assign o_valid  = (r_count != c_CNT_EMPTY);
  assign o_ready  = (r_count != c_CNT_FULL);
  assign o_result = r_head;
  assign w_push   = i_valid && o_ready;
  assign w_pop    = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_count <= c_CNT_EMPTY;
    end else if (i_flush) begin
      r_count <= c_CNT_EMPTY;
    end else begin
      case (r_count)
        c_CNT_EMPTY: if (w_push) r_count <= c_CNT_ONE;
        c_CNT_ONE: begin
          if (w_push && !w_pop)      r_count <= c_CNT_FULL;
          else if (!w_push && w_pop) r_count <= c_CNT_EMPTY;
        end
        c_CNT_FULL: if (w_pop) r_count <= c_CNT_ONE;
        default:    r_count <= c_CNT_EMPTY;
      endcase
    end
  end

  // Data path is not reset; writes during a flush only leave stale values.
  logic w_load_head_new;
  logic w_load_head_skid;
  logic w_load_skid;

  assign w_load_head_new  = w_push && ((r_count == c_CNT_EMPTY) ||
                                       ((r_count == c_CNT_ONE) && w_pop));
  assign w_load_head_skid = w_pop && (r_count == c_CNT_FULL);
  assign w_load_skid      = w_push && !w_pop && (r_count == c_CNT_ONE);

  always_ff @(posedge i_clk) begin
    if (w_load_head_new)       r_head <= w_result;
    else if (w_load_head_skid) r_head <= r_skid;
    if (w_load_skid)           r_skid <= w_result;
  end

`ifdef LOGIC_UNIT_ZFLAG_EN
  logic r_head_zero;
  logic r_skid_zero;
  logic w_zero;

  assign w_zero = (w_result == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_head_zero <= 1'b0;
      r_skid_zero <= 1'b0;
    end else begin
      if (w_load_head_new)       r_head_zero <= w_zero;
      else if (w_load_head_skid) r_head_zero <= r_skid_zero;
      if (w_load_skid)           r_skid_zero <= w_zero;
    end
  end

  assign o_zero = r_head_zero && o_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
// ============================================================================
// Module   : tb_logic_unit_pipe
// Brief    : Directed self-checking bench for logic_unit_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rstn, flush, valid_in, ready_in;
  logic        ready_out, valid_out;
  logic [31:0] op_a, op_b, result;
  logic [2:0]  instr;
`ifdef LOGIC_UNIT_ZFLAG_EN
  logic        zero;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_flush      (flush),
    .i_valid      (valid_in),
    .o_ready      (ready_out),
    .i_opA        (op_a),
    .i_opB        (op_b),
    .i_instr_type (instr),
    .o_valid      (valid_out),
    .i_ready      (ready_in),
    .o_result     (result)
`ifdef LOGIC_UNIT_ZFLAG_EN
    ,
    .o_zero       (zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    valid_in = v;
    instr    = t;
    op_a     = a;
    op_b     = b;
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 32'hFF00_12CB;
    sweep_exp[1] = 32'hFFF0_12FF;
    sweep_exp[2] = 32'h00F0_0034;
    sweep_exp[3] = 32'h00FF_ED34;
    sweep_exp[4] = 32'h000F_ED00;
    sweep_exp[5] = 32'hFF0F_FFCB;
    sweep_exp[6] = 32'hF000_1200;
    sweep_exp[7] = 32'hF0FF_FF34;

    rstn = 1'b0; flush = 1'b0; ready_in = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    #2;
    step();
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd1);
`ifdef LOGIC_UNIT_ZFLAG_EN
    check("rst_zero", {31'd0, zero}, 32'd0);
`endif
    rstn = 1'b1;
    step(); step();
    check("idle_valid", {31'd0, valid_out}, 32'd0);
    check("idle_ready", {31'd0, ready_out}, 32'd1);

    // Op sweep, back-to-back, consumer always ready.
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, t[2:0], 32'hF0F0_1234, 32'h0FF0_00FF);
      step();
      check($sformatf("sweep_valid_%0d", t), {31'd0, valid_out}, 32'd1);
      check($sformatf("sweep_ready_%0d", t), {31'd0, ready_out}, 32'd1);
      check($sformatf("sweep_result_%0d", t), result, sweep_exp[t]);
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    check("sweep_drain", {31'd0, valid_out}, 32'd0);

    // Backpressure: three ops offered continuously, consumer stalled.
    ready_in = 1'b0;
    drive(1'b1, 3'b000, 32'h1, 32'h2);
    step();
    check("bp1_result", result, 32'h3);
    check("bp1_ready", {31'd0, ready_out}, 32'd1);
    drive(1'b1, 3'b001, 32'h4, 32'h8);
    step();
    check("bp2_ready", {31'd0, ready_out}, 32'd0);
    check("bp2_result", result, 32'h3);
    drive(1'b1, 3'b000, 32'h10, 32'h10);
    step();
    check("bp3_ready", {31'd0, ready_out}, 32'd0);
    check("bp3_valid", {31'd0, valid_out}, 32'd1);
    check("bp3_stable", result, 32'h3);
    ready_in = 1'b1;
    step();
    check("bp_pop1", result, 32'hC);
    check("bp_pop1_ready", {31'd0, ready_out}, 32'd1);
    step();
    check("bp_pop2", result, 32'h0);
    check("bp_pop2_valid", {31'd0, valid_out}, 32'd1);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    check("bp_empty", {31'd0, valid_out}, 32'd0);

    // Flush at count 2 with input offered.
    ready_in = 1'b0;
    drive(1'b1, 3'b010, 32'h1, 32'h1);
    step();
    drive(1'b1, 3'b001, 32'h2, 32'h0);
    step();
    check("fl2_full", {31'd0, ready_out}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 3'b001, 32'h5, 32'h0);
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("fl2_valid", {31'd0, valid_out}, 32'd0);
    check("fl2_ready", {31'd0, ready_out}, 32'd1);
    step();
    check("fl2_stays_empty", {31'd0, valid_out}, 32'd0);

    // Flush at count 1 with simultaneous push and pop: both discarded.
    ready_in = 1'b1;
    drive(1'b1, 3'b001, 32'h7, 32'h0);
    step();
    check("fl1_pre", result, 32'h7);
    flush = 1'b1;
    drive(1'b1, 3'b001, 32'h9, 32'h0);
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("fl1_valid", {31'd0, valid_out}, 32'd0);
    step();
    check("fl1_dropped", {31'd0, valid_out}, 32'd0);

    // Reset mid-stall.
    ready_in = 1'b0;
    drive(1'b1, 3'b001, 32'h1, 32'h0);
    step(); step();
    check("rs_full", {31'd0, ready_out}, 32'd0);
    rstn = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    rstn = 1'b1;
    check("rs_valid", {31'd0, valid_out}, 32'd0);
    check("rs_ready", {31'd0, ready_out}, 32'd1);

`ifdef LOGIC_UNIT_ZFLAG_EN
    ready_in = 1'b1;
    drive(1'b1, 3'b010, 32'hFFFF_0000, 32'h0000_FFFF);
    step();
    check("z_result", result, 32'h0);
    check("z_flag", {31'd0, zero}, 32'd1);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    step();
    ready_in = 1'b0;
    drive(1'b1, 3'b000, 32'h1, 32'h2);
    step();
    drive(1'b1, 3'b010, 32'hFFFF_0000, 32'h0000_FFFF);
    step();
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    check("z_head_nz", {31'd0, zero}, 32'd0);
    check("z_head_val", result, 32'h3);
    ready_in = 1'b1;
    step();
    check("z_promoted", {31'd0, zero}, 32'd1);
    check("z_promoted_val", result, 32'h0);
    step();
    check("z_empty", {31'd0, zero}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
